// File: rtl/herald_op_arbiter.sv
// ============================================================================
// Module   : herald_op_arbiter
// Brief    : Round-robin arbiter sharing one CORDIC/MAC engine among NREQ
//            requesters; captures command/operands, starts the engine, returns
//            the tagged result. Optional WAIT timeout: HERALD_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module herald_op_arbiter #(
   parameter int NREQ    = 4,
   parameter int OPW     = 16,
   parameter int RESW    = 32,
   parameter int TIMEOUT = 1023
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [NREQ*8-1:0]         req_cmd,
   input  logic [NREQ*OPW-1:0]       req_opa,
   input  logic [NREQ*OPW-1:0]       req_opb,
   output logic                      eng_start,
   output logic [7:0]                eng_cmd,
   output logic [OPW-1:0]            eng_opa,
   output logic [OPW-1:0]            eng_opb,
   input  logic                      eng_done,
   input  logic [RESW-1:0]           eng_result,
   output logic                      rsp_valid,
   output logic [$clog2(NREQ)-1:0]   rsp_id,
   output logic [RESW-1:0]           rsp_data,
   output logic                      rsp_err,
   input  logic                      rsp_ready
);

   localparam int c_idw = $clog2(NREQ);

   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_issue = 2'd1;
   localparam logic [1:0] c_st_wait  = 2'd2;
   localparam logic [1:0] c_st_resp  = 2'd3;

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [c_idw-1:0] r_rr_ptr;
   logic [c_idw-1:0] r_id;
   logic [7:0]       r_cmd;
   logic [OPW-1:0]   r_opa;
   logic [OPW-1:0]   r_opb;
   logic [RESW-1:0]  r_rsp_data;
   logic             r_rsp_err;

   logic             w_grant_any;
   logic [c_idw-1:0] w_grant_idx;
   logic [7:0]       w_sel_cmd;
   logic [OPW-1:0]   w_sel_opa;
   logic [OPW-1:0]   w_sel_opb;
   logic             w_cmd_ok;
   logic             w_timeout;

   function automatic logic f_cmd_ok(input logic [7:0] cmd);
      case (cmd)
         8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22: return 1'b1;
         default:                                  return 1'b0;
      endcase
   endfunction

   // Scan offsets from far to near so the nearest set bit after rr wins.
   always_comb begin
      int               v_sum;
      logic [c_idw-1:0] v_idx;
      w_grant_any = 1'b0;
      w_grant_idx = '0;
      v_sum       = 0;
      v_idx       = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         v_sum = int'(r_rr_ptr) + k;
         if (v_sum >= NREQ) v_sum = v_sum - NREQ;
         v_idx = c_idw'(v_sum);
         if (req_valid[v_idx]) begin
            w_grant_any = 1'b1;
            w_grant_idx = v_idx;
         end
      end
   end

   always_comb begin
      w_sel_cmd = '0;
      w_sel_opa = '0;
      w_sel_opb = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_grant_idx == c_idw'(i)) begin
            w_sel_cmd = req_cmd[8*i +: 8];
            w_sel_opa = req_opa[OPW*i +: OPW];
            w_sel_opb = req_opb[OPW*i +: OPW];
         end
      end
      w_cmd_ok = f_cmd_ok(w_sel_cmd);
   end

`ifdef HERALD_ARB_TIMEOUT_EN
   localparam int c_tmr_w = $clog2(TIMEOUT + 1);
   logic [c_tmr_w-1:0] r_timer;

   always_ff @(posedge clk) begin
      if (rst)
         r_timer <= '0;
      else if (r_state == c_st_issue)
         r_timer <= '0;
      else if (r_state == c_st_wait && !eng_done)
         r_timer <= r_timer + 1'b1;
   end

   assign w_timeout = (r_state == c_st_wait) && (r_timer == c_tmr_w'(TIMEOUT - 1));
`else
   logic w_unused_timeout;
   assign w_unused_timeout = |TIMEOUT;
   assign w_timeout        = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= c_st_idle;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle:  if (w_grant_any) w_state_nxt = w_cmd_ok ? c_st_issue : c_st_resp;
         c_st_issue: w_state_nxt = c_st_wait;
         c_st_wait:  if (eng_done || w_timeout) w_state_nxt = c_st_resp;
         c_st_resp:  if (rsp_ready) w_state_nxt = c_st_idle;
         default:    w_state_nxt = c_st_idle;
      endcase
   end

   always_comb begin
      req_ready = '0;
      if (r_state == c_st_idle && w_grant_any && !rst) req_ready[w_grant_idx] = 1'b1;
      eng_start = (r_state == c_st_issue);
      rsp_valid = (r_state == c_st_resp);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_ptr   <= '0;
         r_id       <= '0;
         r_cmd      <= '0;
         r_opa      <= '0;
         r_opb      <= '0;
         r_rsp_data <= '0;
         r_rsp_err  <= 1'b0;
      end else begin
         case (r_state)
            c_st_idle: if (w_grant_any) begin
               r_id  <= w_grant_idx;
               r_cmd <= w_sel_cmd;
               r_opa <= w_sel_opa;
               r_opb <= w_sel_opb;
               if (!w_cmd_ok) begin
                  r_rsp_data <= '0;
                  r_rsp_err  <= 1'b1;
               end
            end
            c_st_wait: if (eng_done) begin
               r_rsp_data <= eng_result;
               r_rsp_err  <= 1'b0;
            end else if (w_timeout) begin
               r_rsp_data <= '0;
               r_rsp_err  <= 1'b1;
            end
            c_st_resp: if (rsp_ready)
               r_rr_ptr <= (r_id == c_idw'(NREQ - 1)) ? '0 : r_id + 1'b1;
            default: ;
         endcase
      end
   end

   assign eng_cmd  = r_cmd;
   assign eng_opa  = r_opa;
   assign eng_opb  = r_opb;
   assign rsp_id   = r_id;
   assign rsp_data = r_rsp_data;
   assign rsp_err  = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_herald_op_arbiter.sv
// ============================================================================
// Module   : tb_herald_op_arbiter
// Brief    : Self-checking bench for herald_op_arbiter: transaction model,
//            fake engine, per-cycle compare plus directed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_herald_op_arbiter;

   localparam int NREQ = 4;
   localparam int OPW  = 16;
   localparam int RESW = 32;
   localparam int TO   = 16;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*8-1:0]     req_cmd;
   logic [NREQ*OPW-1:0]   req_opa;
   logic [NREQ*OPW-1:0]   req_opb;
   logic                  eng_start;
   logic [7:0]            eng_cmd;
   logic [OPW-1:0]        eng_opa;
   logic [OPW-1:0]        eng_opb;
   logic                  eng_done;
   logic [RESW-1:0]       eng_result;
   logic                  rsp_valid;
   logic [1:0]            rsp_id;
   logic [RESW-1:0]       rsp_data;
   logic                  rsp_err;
   logic                  rsp_ready;

   herald_op_arbiter #(.NREQ(NREQ), .OPW(OPW), .RESW(RESW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
      .req_opa(req_opa), .req_opb(req_opb),
      .eng_start(eng_start), .eng_cmd(eng_cmd), .eng_opa(eng_opa), .eng_opb(eng_opb),
      .eng_done(eng_done), .eng_result(eng_result),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .rsp_err(rsp_err), .rsp_ready(rsp_ready)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [NREQ-1:0] v, input int rr);
      for (int k = 0; k < NREQ; k++)
         if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
      return -1;
   endfunction

   function automatic bit cmd_known(input logic [7:0] c);
      return c inside {8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};
   endfunction

   function automatic logic [31:0] fake(input logic [7:0] c, input logic [15:0] a, input logic [15:0] b);
      logic [31:0] p;
      p = (32'(a) * 32'(b)) >> 8;
      if (c == 8'h20) return {16'h0, p[15:0]};
      return {c, 8'h5A, a ^ b};
   endfunction

   // Fake engine: answers eng_start after eng_lat cycles; stray_req forces a lone done pulse.
   int eng_lat   = 5;
   bit eng_auto  = 1'b1;
   int stray_req = 0;
   initial begin
      int cd, stray_seen;
      logic [7:0]  c;
      logic [15:0] a, b;
      cd = 0; stray_seen = 0; c = 0; a = 0; b = 0;
      eng_done = 1'b0; eng_result = '0;
      forever begin
         @(negedge clk);
         if (eng_start && eng_auto) begin cd = eng_lat; c = eng_cmd; a = eng_opa; b = eng_opb; end
         @(posedge clk); #1;
         eng_done = 1'b0;
         if (cd > 0) begin
            cd--;
            if (cd == 0) begin eng_done = 1'b1; eng_result = fake(c, a, b); end
         end
         if (stray_req != stray_seen) begin
            stray_seen = stray_req; eng_done = 1'b1; eng_result = 32'hDEADBEEF;
         end
      end
   end

   // Transaction-level model of one operation in flight.
   bit          m_active, m_started, m_have_rsp, m_err;
   int          m_rr, m_id, m_wait;
   logic [7:0]  m_cmd;
   logic [15:0] m_a, m_b;
   logic [31:0] m_data;
   initial begin
      int g;
      m_active = 0; m_started = 0; m_have_rsp = 0; m_err = 0;
      m_rr = 0; m_id = 0; m_wait = 0; m_cmd = 0; m_a = 0; m_b = 0; m_data = 0;
      forever begin
         @(posedge clk);
         if (rst) begin
            m_active = 0; m_started = 0; m_have_rsp = 0; m_err = 0;
            m_rr = 0; m_id = 0; m_cmd = 0; m_a = 0; m_b = 0; m_data = 0;
         end else if (!m_active) begin
            g = pick(req_valid, m_rr);
            if (g >= 0) begin
               m_active = 1; m_id = g;
               m_cmd = req_cmd[8*g +: 8]; m_a = req_opa[16*g +: 16]; m_b = req_opb[16*g +: 16];
               if (cmd_known(m_cmd)) m_started = 0;
               else begin m_started = 1; m_have_rsp = 1; m_err = 1; m_data = 0; end
            end
         end else if (!m_started) begin
            m_started = 1; m_wait = 0;
         end else if (!m_have_rsp) begin
            if (eng_done) begin m_have_rsp = 1; m_data = eng_result; m_err = 0; end
`ifdef HERALD_ARB_TIMEOUT_EN
            else begin
               m_wait++;
               if (m_wait == TO) begin m_have_rsp = 1; m_data = 0; m_err = 1; end
            end
`endif
         end else if (rsp_ready) begin
            m_active = 0; m_have_rsp = 0; m_rr = (m_id + 1) % NREQ;
         end
      end
   end

   int grants[$];
   int start_cnt = 0;
   initial begin
      logic [NREQ-1:0] er;
      int g;
      forever begin
         @(negedge clk);
         for (int i = 0; i < NREQ; i++) if (req_ready[i]) grants.push_back(i);
         if (eng_start) start_cnt++;
         if (chk_en) begin
            er = '0;
            g  = pick(req_valid, m_rr);
            if (!rst && !m_active && g >= 0) er[g] = 1'b1;
            check("req_ready", req_ready, er);
            check("eng_start", eng_start, m_active && !m_started);
            check("rsp_valid", rsp_valid, m_have_rsp);
            check("eng_operands", {eng_cmd, eng_opa, eng_opb}, {m_cmd, m_a, m_b});
            if (m_have_rsp) check("rsp_fields", {rsp_id, rsp_err, rsp_data}, {2'(m_id), m_err, m_data});
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic set_req(input int i, input logic [7:0] c, input logic [15:0] a, input logic [15:0] b);
      req_cmd[8*i +: 8] = c; req_opa[16*i +: 16] = a; req_opb[16*i +: 16] = b; req_valid[i] = 1'b1;
   endtask

   task automatic wait_ready(input int i, input string name);
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (req_ready[i]) return;
      end
      check(name, 0, 1);
   endtask

   task automatic wait_rsp(input string name);
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (rsp_valid) return;
      end
      check(name, 0, 1);
   endtask

   initial begin
      int base, s0;
      logic [34:0] held;
      rst = 1'b1; req_valid = '0; req_cmd = '0; req_opa = '0; req_opb = '0; rsp_ready = 1'b1;
      @(posedge clk); #1 chk_en = 1'b1;
      step(); step();
      @(negedge clk);
      check("reset_outputs", {req_ready, eng_start, eng_cmd, eng_opa, eng_opb, rsp_valid, rsp_id, rsp_err}, 0);
      check("reset_rsp_data", rsp_data, 0);
      step(); rst = 1'b0;
      repeat (3) step();
      @(negedge clk);
      check("idle_no_activity", {req_ready, eng_start, rsp_valid}, 0);

      // Round robin with every requester holding a request.
      base = grants.size();
      step();
      set_req(0, 8'h10, 16'h0100, 16'h0001); set_req(1, 8'h11, 16'h0200, 16'h0002);
      set_req(2, 8'h12, 16'h0300, 16'h0003); set_req(3, 8'h20, 16'h0400, 16'h0004);
      for (int n = 0; n < 300 && grants.size() < base + 5; n++) @(negedge clk);
      step(); req_valid = '0;
      check("rr_grant_count", grants.size() - base, 5);
      if (grants.size() >= base + 5) begin
         check("rr_grant0", grants[base + 0], 0); check("rr_grant1", grants[base + 1], 1);
         check("rr_grant2", grants[base + 2], 2); check("rr_grant3", grants[base + 3], 3);
         check("rr_grant4", grants[base + 4], 0);
      end
      repeat (15) step();

      // Single multiply request on requester 0.
      set_req(0, 8'h20, 16'h0200, 16'h0180);
      wait_ready(0, "single_grant_timeout");
      step(); req_valid = '0;
      wait_rsp("single_rsp_timeout");
      check("single_rsp", {rsp_id, rsp_err, rsp_data}, {2'd0, 1'b0, 32'h00000300});
      repeat (3) step();

      // Unknown command never reaches the engine.
      s0 = start_cnt;
      set_req(2, 8'h55, 16'h1111, 16'h2222);
      wait_ready(2, "badcmd_grant_timeout");
      step(); req_valid = '0;
      wait_rsp("badcmd_rsp_timeout");
      check("badcmd_rsp", {rsp_id, rsp_err, rsp_data}, {2'd2, 1'b1, 32'h0});
      repeat (3) step();
      check("badcmd_no_start", start_cnt - s0, 0);

      // Backpressure: response held, competing request must wait.
      rsp_ready = 1'b0;
      set_req(1, 8'h11, 16'h1234, 16'h0042);
      wait_ready(1, "bp_grant_timeout");
      step(); req_valid[1] = 1'b0;
      set_req(3, 8'h12, 16'h00FF, 16'h0F0F);
      wait_rsp("bp_rsp_timeout");
      held = {rsp_id, rsp_err, rsp_data};
      check("bp_rsp_literal", held, {2'd1, 1'b0, 32'h115A1276});
      for (int n = 0; n < 10; n++) begin
         step();
         @(negedge clk);
         check("bp_rsp_stable", {rsp_valid, rsp_id, rsp_err, rsp_data}, {1'b1, held});
         check("bp_no_grant", req_ready, 0);
      end
      step(); rsp_ready = 1'b1;
      wait_ready(3, "bp_next_grant_timeout");
      step(); req_valid = '0;
      wait_rsp("bp_next_rsp_timeout");
      check("bp_next_id", rsp_id, 3);
      repeat (3) step();

      // Stray done while idle is ignored.
      stray_req++;
      repeat (3) step();
      @(negedge clk);
      check("stray_idle", rsp_valid, 0);

      // Reset while waiting on the engine drops the operation.
      set_req(0, 8'h21, 16'h0A0A, 16'h0505);
      wait_ready(0, "midrst_grant_timeout");
      step(); req_valid = '0;
      step(); step();
      rst = 1'b1; step(); rst = 1'b0;
      repeat (10) step();
      @(negedge clk);
      check("midrst_no_rsp", {rsp_valid, eng_start, eng_cmd}, 0);

`ifdef HERALD_ARB_TIMEOUT_EN
      begin
         int cnt;
         eng_auto = 1'b0; rsp_ready = 1'b0;
         set_req(1, 8'h12, 16'h0001, 16'h0002);
         wait_ready(1, "to_grant_timeout");
         step(); req_valid = '0;
         @(negedge clk);
         check("to_start", eng_start, 1);
         cnt = 0;
         for (int n = 0; n < 40 && !rsp_valid; n++) begin @(negedge clk); cnt++; end
         check("to_latency", cnt, TO + 1);
         check("to_rsp", {rsp_id, rsp_err, rsp_data}, {2'd1, 1'b1, 32'h0});
         step(); stray_req++;
         repeat (3) step();
         @(negedge clk);
         check("to_stray_ignored", {rsp_valid, rsp_err, rsp_data}, {1'b1, 1'b1, 32'h0});
         step(); rsp_ready = 1'b1; eng_auto = 1'b1;
         repeat (3) step();
      end
`endif

      repeat (3) step();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
      $fatal(1);
   end

endmodule

`default_nettype wire
